// File: rtl/cpu_mem_responder_if.sv
// CPU request bus and PRG ROM fetch channel as seen by cpu_mem_responder.
// master = CPU/ROM side, slave = responder.
interface cpu_mem_responder_if;
    logic        memory_access;
    logic        rw_n;
    logic [15:0] addr_bus;
    logic [7:0]  mem_data_out;
    logic [7:0]  mem_data_in;
    logic        mem_ready;
    logic        prg_req;
    logic [14:0] prg_addr;
    logic [7:0]  prg_data;
    logic        prg_valid;
    logic        bus_error;

    modport slave (
        input  memory_access, rw_n, addr_bus, mem_data_out, prg_data, prg_valid,
        output mem_data_in, mem_ready, prg_req, prg_addr, bus_error
    );

    modport master (
        output memory_access, rw_n, addr_bus, mem_data_out, prg_data, prg_valid,
        input  mem_data_in, mem_ready, prg_req, prg_addr, bus_error
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// CPU memory responder: 2 KiB mirrored RAM, PRG ROM fetch, open-bus for unmapped reads.
// Optional ROM fetch timeout enabled by defining CPU_MEM_RESP_ROM_TIMEOUT_EN.
module cpu_mem_responder (
    input  logic                       clk,
    input  logic                       rst_n,
    cpu_mem_responder_if.slave         bus
);
    typedef enum logic [2:0] {IDLE, RAM_ACC, ROM_WAIT, RESP, GAP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [10:0] r_ram_idx;
    logic        r_rw_n;
    logic [7:0]  r_wdata;
    logic [7:0]  r_data_in;
    logic        r_prg_req;
    logic [14:0] r_prg_addr;
    logic        r_bus_error;
    logic [7:0]  r_ram [0:2047];

    logic        w_is_ram;
    logic        w_is_rom;
    logic        w_accept;
    logic        w_rom_done;
    logic        w_timeout;
    logic        w_ram_we;

    assign w_is_ram = (bus.addr_bus[15:13] == 3'b000);
    assign w_is_rom = bus.addr_bus[15];

`ifdef CPU_MEM_RESP_ROM_TIMEOUT_EN
    logic [3:0]  r_tmo_cnt;
    // 15th ROM_WAIT edge without prg_valid gives up
    assign w_timeout = (r_state == ROM_WAIT) && !bus.prg_valid && (r_tmo_cnt == 4'd14);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_tmo_cnt <= 4'd0;
        else if (w_accept)
            r_tmo_cnt <= 4'd0;
        else if (r_state == ROM_WAIT)
            r_tmo_cnt <= r_tmo_cnt + 4'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_rom_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.memory_access) begin
                    w_accept = 1'b1;
                    if (w_is_ram)
                        w_state_next = RAM_ACC;
                    else if (w_is_rom && bus.rw_n)
                        w_state_next = ROM_WAIT;
                    else
                        w_state_next = RESP;
                end
            end
            RAM_ACC:  w_state_next = RESP;
            ROM_WAIT: begin
                if (bus.prg_valid) begin
                    w_rom_done   = 1'b1;
                    w_state_next = RESP;
                end else if (w_timeout) begin
                    w_state_next = RESP;
                end
            end
            RESP:     w_state_next = GAP;
            GAP:      w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // A reset on the RAM_ACC edge itself abandons the write
    assign w_ram_we = (r_state == RAM_ACC) && !r_rw_n && rst_n;

    always_ff @(posedge clk) begin
        if (w_ram_we)
            r_ram[r_ram_idx] <= r_wdata;
    end

    // r_data_in doubles as the open-bus latch: unmapped reads simply leave it alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ram_idx   <= 11'd0;
            r_rw_n      <= 1'b1;
            r_wdata     <= 8'h00;
            r_data_in   <= 8'h00;
            r_prg_req   <= 1'b0;
            r_prg_addr  <= 15'd0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_ram_idx <= bus.addr_bus[10:0];
                r_rw_n    <= bus.rw_n;
                r_wdata   <= bus.mem_data_out;
                if (w_is_rom && bus.rw_n) begin
                    r_prg_req  <= 1'b1;
                    r_prg_addr <= bus.addr_bus[14:0];
                end
                if (w_is_rom && !bus.rw_n)
                    r_bus_error <= 1'b1;
            end
            if ((r_state == RAM_ACC) && r_rw_n)
                r_data_in <= r_ram[r_ram_idx];
            if (w_rom_done) begin
                r_data_in <= bus.prg_data;
                r_prg_req <= 1'b0;
            end else if (w_timeout) begin
                r_data_in   <= 8'hFF;
                r_prg_req   <= 1'b0;
                r_bus_error <= 1'b1;
            end
        end
    end

    assign bus.mem_data_in = r_data_in;
    assign bus.mem_ready   = (r_state == RESP);
    assign bus.prg_req     = r_prg_req;
    assign bus.prg_addr    = r_prg_addr;
    assign bus.bus_error   = r_bus_error;
endmodule
